// File: rtl/cmsdk_ahb_to_ahb_apb_async_pkg.sv
// Shared definitions for the asynchronous AHB-to-AHB/APB bridge crossing logic:
// one-hot handshake states and synchroniser depth limits.
package cmsdk_ahb_to_ahb_apb_async_pkg;

  localparam int STATE_W         = 4;
  localparam int SYNC_STAGES_MIN = 2;
  localparam int SYNC_STAGES_MAX = 3;

  // Bit positions of each state inside the one-hot vector, so outputs can be
  // taken straight from a single state flop.
  localparam int IDX_IDLE   = 0;
  localparam int IDX_SAMPLE = 1;
  localparam int IDX_VALID  = 2;
  localparam int IDX_ACK    = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE   = 4'b0001,
    ST_SAMPLE = 4'b0010,
    ST_VALID  = 4'b0100,
    ST_ACK    = 4'b1000
  } state_t;

endpackage

// File: rtl/cmsdk_ahb_to_ahb_apb_async_sync.sv
// N-flop single-bit level synchroniser with asynchronous active-low reset.
// Used for the request in the destination domain and the acknowledge in the source domain.
module cmsdk_ahb_to_ahb_apb_async_sync #(
  parameter int N = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [N-1:0] sync_ff;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_ff <= '0;
    end else begin
      sync_ff <= {sync_ff[N-2:0], d};
    end
  end

  assign q = sync_ff[N-1];

endmodule

// File: rtl/cmsdk_ahb_to_ahb_apb_async_rx_ctrl.sv
// Destination-side 4-phase handshake controller: synchronises REQ_ASYNC, pulses the
// sample-and-hold enable, presents the held payload with VALID/READY and returns ACK.
module cmsdk_ahb_to_ahb_apb_async_rx_ctrl
  import cmsdk_ahb_to_ahb_apb_async_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic CLK,
  input  logic RESETn,
  input  logic REQ_ASYNC,
  output logic ACK,
  output logic SH_EN,
  output logic SH_MASK,
  output logic VALID,
  input  logic READY,
  output logic PROT_ERR
);

  if ((SYNC_STAGES < SYNC_STAGES_MIN) || (SYNC_STAGES > SYNC_STAGES_MAX)) begin : g_bad_sync_stages
    $error("SYNC_STAGES must be 2 or 3");
  end

  logic   req_s;
  state_t state_q;
  state_t state_d;
  logic   prot_err_q;

  cmsdk_ahb_to_ahb_apb_async_sync #(
    .N (SYNC_STAGES)
  ) u_req_sync (
    .clk   (CLK),
    .rst_n (RESETn),
    .d     (REQ_ASYNC),
    .q     (req_s)
  );

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // SAMPLE always lasts one cycle so the bank captures exactly once per transfer.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (req_s) state_d = ST_SAMPLE;
      ST_SAMPLE: state_d = ST_VALID;
      ST_VALID:  if (READY) state_d = ST_ACK;
      ST_ACK:    if (!req_s) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // A request withdrawn before it was acknowledged is flagged but not acted on.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      prot_err_q <= 1'b0;
    end else if (!req_s && (state_q[IDX_SAMPLE] || state_q[IDX_VALID])) begin
      prot_err_q <= 1'b1;
    end
  end

  // Each output follows one state flop, so none can glitch; the mask only opens in VALID.
  assign ACK      = state_q[IDX_ACK];
  assign SH_EN    = state_q[IDX_SAMPLE];
  assign VALID    = state_q[IDX_VALID];
  assign SH_MASK  = ~state_q[IDX_VALID];
  assign PROT_ERR = prot_err_q;

endmodule

// File: tb/tb_cmsdk_ahb_to_ahb_apb_async_rx_ctrl.sv
// Self-checking bench for the rx handshake controller (SYNC_STAGES 2 and 3 instances)
// with a 32-bit behavioural sample-and-hold bank model per instance.
module tb_cmsdk_ahb_to_ahb_apb_async_rx_ctrl;

  typedef struct {
    logic        req;
    logic        ready;
    logic [31:0] d;
    logic        ack;
    logic        en;
    logic        mask;
    logic        valid;
    logic        perr;
    logic [31:0] q;
  } vec_t;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [31:0] d = '0;
  logic        req2 = 1'b0, ready2 = 1'b0;
  logic        req3 = 1'b0, ready3 = 1'b0;
  logic        ack2, en2, mask2, valid2, perr2;
  logic        ack3, en3, mask3, valid3, perr3;
  logic [31:0] bank2 = '0, bank3 = '0;
  logic [31:0] q2, q3;

  int checkCount = 0;
  int passCount  = 0;

  vec_t tbl2[$];
  vec_t tbl3[$];

  bit          monOn = 1'b0;
  int          enCount = 0;
  int          zeroViol = 0;
  logic        prevValid2 = 1'b0;
  logic [31:0] capQ[$];

  always #5 clk = ~clk;

  cmsdk_ahb_to_ahb_apb_async_rx_ctrl #(.SYNC_STAGES(2)) dut2 (
    .CLK(clk), .RESETn(resetn), .REQ_ASYNC(req2), .ACK(ack2), .SH_EN(en2),
    .SH_MASK(mask2), .VALID(valid2), .READY(ready2), .PROT_ERR(perr2)
  );

  cmsdk_ahb_to_ahb_apb_async_rx_ctrl #(.SYNC_STAGES(3)) dut3 (
    .CLK(clk), .RESETn(resetn), .REQ_ASYNC(req3), .ACK(ack3), .SH_EN(en3),
    .SH_MASK(mask3), .VALID(valid3), .READY(ready3), .PROT_ERR(perr3)
  );

  // Sample-and-hold bank models: capture on enable, output forced to zero by mask.
  always @(posedge clk) begin
    if (en2) bank2 <= d;
    if (en3) bank3 <= d;
  end
  assign q2 = mask2 ? 32'h0 : bank2;
  assign q3 = mask3 ? 32'h0 : bank3;

  always @(negedge clk) begin
    if (monOn) begin
      if (en2) enCount++;
      if (valid2 && !prevValid2) capQ.push_back(q2);
      if (!valid2 && (q2 !== 32'h0)) zeroViol++;
      prevValid2 = valid2;
    end
  end

  function automatic vec_t mk(logic req, logic ready, logic [31:0] dv, logic ack, logic en,
                              logic mask, logic valid, logic perr, logic [31:0] q);
    vec_t v;
    v.req = req; v.ready = ready; v.d = dv; v.ack = ack; v.en = en;
    v.mask = mask; v.valid = valid; v.perr = perr; v.q = q;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [36:0] act, input logic [36:0] exp);
    checkCount++;
    if (act === exp) passCount++;
    else $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic applyStimulus(input vec_t v, input bit useS3);
    @(negedge clk);
    d = v.d;
    if (useS3) begin req3 = v.req; ready3 = v.ready; end
    else       begin req2 = v.req; ready2 = v.ready; end
  endtask

  task automatic runTable(input bit useS3, input string tag);
    vec_t v;
    int   n;
    logic [36:0] act, exp;
    n = useS3 ? tbl3.size() : tbl2.size();
    for (int i = 0; i < n; i++) begin
      v = useS3 ? tbl3[i] : tbl2[i];
      applyStimulus(v, useS3);
      @(posedge clk);
      #1;
      exp = {v.ack, v.en, v.mask, v.valid, v.perr, v.q};
      act = useS3 ? {ack3, en3, mask3, valid3, perr3, q3} : {ack2, en2, mask2, valid2, perr2, q2};
      checkOutput($sformatf("%s_row%0d", tag, i + 1), act, exp);
    end
  endtask

  task automatic runResetCheck();
    int guard;
    @(negedge clk); req2 = 1'b1; ready2 = 1'b0; d = 32'hCAFE_0001;
    guard = 0;
    while (valid2 !== 1'b1 && guard < 20) begin @(negedge clk); guard++; end
    checkOutput("rst_reach_valid", {36'h0, valid2}, 37'h1);
    #2 resetn = 1'b0;
    #1 checkOutput("rst_async_outputs", {32'h0, ack2, en2, mask2, valid2, perr2}, {32'h0, 5'b00100});
    @(negedge clk); resetn = 1'b1;
    guard = 0;
    while (en2 !== 1'b1 && guard < 20) begin @(negedge clk); guard++; end
    checkOutput("rst_pending_req_restarts", {36'h0, en2}, 37'h1);
    ready2 = 1'b1;
    guard = 0;
    while (ack2 !== 1'b1 && guard < 20) begin @(negedge clk); guard++; end
    checkOutput("rst_restart_ack", {36'h0, ack2}, 37'h1);
    req2 = 1'b0;
    guard = 0;
    while (ack2 !== 1'b0 && guard < 20) begin @(negedge clk); guard++; end
    checkOutput("rst_restart_ack_fall", {36'h0, ack2}, 37'h0);
    ready2 = 1'b0;
  endtask

  task automatic runBackToBack();
    int guard;
    enCount = 0; zeroViol = 0; prevValid2 = 1'b0; capQ.delete();
    @(negedge clk); monOn = 1'b1;
    for (int t = 1; t <= 3; t++) begin
      @(negedge clk); d = t; req2 = 1'b1;
      guard = 0;
      while (ack2 !== 1'b1 && guard < 60) begin
        @(negedge clk);
        ready2 = (guard > 20) ? 1'b1 : 1'($urandom_range(0, 1));
        guard++;
      end
      checkOutput($sformatf("b2b_ack_rise_%0d", t), {36'h0, ack2}, 37'h1);
      req2 = 1'b0;
      guard = 0;
      while (ack2 !== 1'b0 && guard < 20) begin @(negedge clk); guard++; end
      checkOutput($sformatf("b2b_ack_fall_%0d", t), {36'h0, ack2}, 37'h0);
    end
    repeat (3) @(negedge clk);
    monOn = 1'b0;
    ready2 = 1'b0;
    checkOutput("b2b_sh_en_pulses", 37'(enCount), 37'd3);
    checkOutput("b2b_capture_count", 37'(capQ.size()), 37'd3);
    for (int i = 0; i < 3 && i < capQ.size(); i++)
      checkOutput($sformatf("b2b_q_%0d", i + 1), {5'h0, capQ[i]}, 37'(i + 1));
    checkOutput("b2b_q_zero_when_idle", 37'(zeroViol), 37'd0);
  endtask

  initial begin
    // Basic transfer with READY high, then ACK release three edges after REQ falls.
    tbl2.push_back(mk(1, 1, 32'hA5A5_1234, 0, 0, 1, 0, 0, 32'h0));
    tbl2.push_back(mk(1, 1, 32'hA5A5_1234, 0, 0, 1, 0, 0, 32'h0));
    tbl2.push_back(mk(1, 1, 32'hA5A5_1234, 0, 1, 1, 0, 0, 32'h0));
    tbl2.push_back(mk(1, 1, 32'hA5A5_1234, 0, 0, 0, 1, 0, 32'hA5A5_1234));
    tbl2.push_back(mk(1, 1, 32'hA5A5_1234, 1, 0, 1, 0, 0, 32'h0));
    tbl2.push_back(mk(0, 1, 32'hA5A5_1234, 1, 0, 1, 0, 0, 32'h0));
    tbl2.push_back(mk(0, 1, 32'hA5A5_1234, 1, 0, 1, 0, 0, 32'h0));
    tbl2.push_back(mk(0, 1, 32'hA5A5_1234, 0, 0, 1, 0, 0, 32'h0));
    // Backpressure: READY ignored before VALID, then held low for 10 VALID cycles.
    tbl2.push_back(mk(1, 1, 32'hDEAD_BEEF, 0, 0, 1, 0, 0, 32'h0));
    tbl2.push_back(mk(1, 1, 32'hDEAD_BEEF, 0, 0, 1, 0, 0, 32'h0));
    tbl2.push_back(mk(1, 1, 32'hDEAD_BEEF, 0, 1, 1, 0, 0, 32'h0));
    tbl2.push_back(mk(1, 0, 32'hDEAD_BEEF, 0, 0, 0, 1, 0, 32'hDEAD_BEEF));
    for (int i = 0; i < 9; i++)
      tbl2.push_back(mk(1, 0, 32'h0, 0, 0, 0, 1, 0, 32'hDEAD_BEEF));
    tbl2.push_back(mk(1, 1, 32'h0, 1, 0, 1, 0, 0, 32'h0));
    tbl2.push_back(mk(0, 1, 32'h0, 1, 0, 1, 0, 0, 32'h0));
    tbl2.push_back(mk(0, 0, 32'h0, 1, 0, 1, 0, 0, 32'h0));
    tbl2.push_back(mk(0, 0, 32'h0, 0, 0, 1, 0, 0, 32'h0));
    // Early request drop during VALID: sticky PROT_ERR, transfer still completes.
    tbl2.push_back(mk(1, 0, 32'h1357_9BDF, 0, 0, 1, 0, 0, 32'h0));
    tbl2.push_back(mk(1, 0, 32'h1357_9BDF, 0, 0, 1, 0, 0, 32'h0));
    tbl2.push_back(mk(1, 0, 32'h1357_9BDF, 0, 1, 1, 0, 0, 32'h0));
    tbl2.push_back(mk(1, 0, 32'h1357_9BDF, 0, 0, 0, 1, 0, 32'h1357_9BDF));
    tbl2.push_back(mk(0, 0, 32'h1357_9BDF, 0, 0, 0, 1, 0, 32'h1357_9BDF));
    tbl2.push_back(mk(0, 0, 32'h1357_9BDF, 0, 0, 0, 1, 0, 32'h1357_9BDF));
    tbl2.push_back(mk(0, 1, 32'h1357_9BDF, 1, 0, 1, 0, 1, 32'h0));
    tbl2.push_back(mk(0, 0, 32'h1357_9BDF, 0, 0, 1, 0, 1, 32'h0));
    tbl2.push_back(mk(0, 0, 32'h1357_9BDF, 0, 0, 1, 0, 1, 32'h0));

    // SYNC_STAGES=3 basic transfer: VALID after edge 5, ACK falls 4 edges after REQ.
    tbl3.push_back(mk(1, 1, 32'hA5A5_1234, 0, 0, 1, 0, 0, 32'h0));
    tbl3.push_back(mk(1, 1, 32'hA5A5_1234, 0, 0, 1, 0, 0, 32'h0));
    tbl3.push_back(mk(1, 1, 32'hA5A5_1234, 0, 0, 1, 0, 0, 32'h0));
    tbl3.push_back(mk(1, 1, 32'hA5A5_1234, 0, 1, 1, 0, 0, 32'h0));
    tbl3.push_back(mk(1, 1, 32'hA5A5_1234, 0, 0, 0, 1, 0, 32'hA5A5_1234));
    tbl3.push_back(mk(1, 1, 32'hA5A5_1234, 1, 0, 1, 0, 0, 32'h0));
    tbl3.push_back(mk(0, 1, 32'hA5A5_1234, 1, 0, 1, 0, 0, 32'h0));
    tbl3.push_back(mk(0, 1, 32'hA5A5_1234, 1, 0, 1, 0, 0, 32'h0));
    tbl3.push_back(mk(0, 1, 32'hA5A5_1234, 1, 0, 1, 0, 0, 32'h0));
    tbl3.push_back(mk(0, 1, 32'hA5A5_1234, 0, 0, 1, 0, 0, 32'h0));

    repeat (3) @(negedge clk);
    checkOutput("reset_state_s2", {32'h0, ack2, en2, mask2, valid2, perr2}, {32'h0, 5'b00100});
    checkOutput("reset_state_s3", {32'h0, ack3, en3, mask3, valid3, perr3}, {32'h0, 5'b00100});
    resetn = 1'b1;
    repeat (2) @(negedge clk);

    $display("[TB] table-driven S=2 sequence");
    runTable(1'b0, "s2");
    $display("[TB] asynchronous reset during VALID");
    runResetCheck();
    $display("[TB] back-to-back transfers");
    runBackToBack();
    $display("[TB] table-driven S=3 sequence");
    runTable(1'b1, "s3");

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/cmsdk_ahb_to_ahb_apb_async_rx_ctrl.md
# cmsdk_ahb_to_ahb_apb_async_rx_ctrl

Destination-domain handshake controller for the asynchronous AHB-to-AHB/APB bridge. It synchronises the 4-phase request arriving from the source clock domain and drives the enable and mask inputs of the sample-and-hold cells that capture the crossing payload. It presents the captured payload downstream with a VALID/READY handshake and returns a flop-driven acknowledge to the source domain. One instance sits beside each sample-and-hold bank, in the bank's clock domain.

## Interface
Parameters:
- SYNC_STAGES, 2, synchroniser depth on REQ_ASYNC; legal values 2 or 3.

Ports:
- CLK  in  1  destination-domain clock; the same clock as the controlled sample-and-hold cells.
- RESETn  in  1  reset; asynchronous, active-low.
- REQ_ASYNC  in  1  4-phase request level from the source domain; the payload is stable while this is high.
- ACK  out  1  4-phase acknowledge to the source domain; driven directly by a flop.
- SH_EN  out  1  enable to the sample-and-hold bank; one-cycle pulse per transfer.
- SH_MASK  out  1  mask to the sample-and-hold bank; 1 forces the bank output Q to 0.
- VALID  out  1  the sampled payload on the bank Q is valid downstream.
- READY  in  1  downstream accept; only meaningful while VALID=1.
- PROT_ERR  out  1  sticky flag: REQ_ASYNC fell before ACK was raised.

## Operation
- REQ_ASYNC passes through a SYNC_STAGES flop synchroniser to give req_s. All synchroniser flops reset to 0.
- The FSM is one-hot: IDLE, SAMPLE, VALID, ACK. All outputs are registered or decoded from a single state flop, so they are glitch-free.
- IDLE:
  - Outputs: ACK=0, SH_MASK=1, SH_EN=0, VALID=0.
  - req_s=1 moves to SAMPLE.
- SAMPLE:
  - Outputs: SH_EN=1, SH_MASK=1.
  - Always moves to VALID on the next edge. The bank captures D on that edge.
- VALID:
  - Outputs: VALID=1, SH_MASK=0, so Q carries the payload.
  - READY=1 moves to ACK.
  - READY=0 holds the state indefinitely.
- ACK:
  - Outputs: ACK=1, SH_MASK=1, VALID=0.
  - req_s=0 moves to IDLE, and ACK falls on that edge.
- Protocol error:
  - req_s=0 observed in SAMPLE or VALID sets PROT_ERR.
  - The transfer still completes normally; no state is skipped.
  - PROT_ERR is cleared only by reset.
- READY is ignored outside VALID.
- If READY=1 in the first VALID cycle, the transfer is accepted immediately and VALID lasts exactly one cycle.
- Reset at any point:
  - FSM returns to IDLE and the synchroniser clears.
  - Output values: ACK=0, SH_EN=0, SH_MASK=1, VALID=0, PROT_ERR=0.
  - A source-side request still pending after reset is treated as a new transfer.

## Timing
Edge numbering: REQ_ASYNC rises before edge 1; S = SYNC_STAGES.
- req_s goes high after edge S. SAMPLE is entered at edge S+1, so SH_EN is high between edges S+1 and S+2.
- The bank captures D at edge S+2. VALID=1 and SH_MASK=0 after edge S+2.
- READY=1 sampled at edge k while VALID=1 gives ACK=1, VALID=0 and SH_MASK=1 after edge k.
- After REQ_ASYNC falls, ACK falls S+1 edges later.
- Throughput: at most one transfer per (2S + 4 + source-side synchroniser latency) cycles.
- SH_MASK never rises or falls in the same cycle that SH_EN is high. Q is masked throughout capture.

## Structure
- Shared package cmsdk_ahb_to_ahb_apb_async_pkg holds:
  - one-hot state encodings (ST_IDLE, ST_SAMPLE, ST_VALID, ST_ACK) and the state width;
  - SYNC_STAGES minimum and maximum constants.
- Sub-module cmsdk_ahb_to_ahb_apb_async_sync:
  - parameterised N-flop single-bit synchroniser with asynchronous active-low reset;
  - reused for the source-side ACK synchroniser.
- The controller instantiates the sync once. The sample-and-hold bank stays external, driven by SH_EN and SH_MASK.

## Test plan
- Reset check: assert RESETn=0 mid-VALID -> ACK=0, SH_EN=0, SH_MASK=1, VALID=0 and PROT_ERR=0 immediately, without a clock edge.
- Basic transfer, S=2, bank width 32, payload 0xA5A5_1234, READY tied 1:
  - SH_EN pulses high between edges 3 and 4; VALID is high for exactly one cycle after edge 4 with Q=0xA5A5_1234;
  - ACK rises after edge 5;
  - REQ_ASYNC is dropped after ACK rises -> ACK falls 3 edges later.
- Backpressure: hold READY=0 for 10 cycles -> VALID and Q stay stable with SH_MASK=0; ACK stays 0 until the READY=1 edge.
- Early request drop: drop REQ_ASYNC during VALID -> PROT_ERR=1 sticky, transfer completes, ACK=1 until req_s=0.
- Back-to-back: 3 transfers with payloads 0x1, 0x2, 0x3 and randomized READY -> exactly 3 SH_EN pulses; Q in VALID equals 0x1, 0x2, 0x3 in order; Q=0 whenever VALID=0.
- S=3 build: repeat the basic transfer -> VALID asserted after edge 5.
